// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate strobe, h/v counters, registered sync and
// visible-area decode aligned with the counters, plus a per-frame tick and frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_next;
    logic [9:0]       v_next;

    // Active-low sync: low while the counter is inside the sync window.
    function automatic logic sync_level(input logic [9:0] cnt, input logic [9:0] width);
        return !(cnt < width);
    endfunction

    function automatic logic in_window(input logic [9:0] cnt, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

    assign pix_en     = (div_cnt == DIV_LAST);
    assign frame_tick = pix_en && (hCount == H_LAST) && (vCount == V_LAST);

    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (pix_en) begin
            if (hCount < H_LAST) begin
                h_next = hCount + 10'd1;
            end else begin
                h_next = '0;
                v_next = (vCount < V_LAST) ? vCount + 10'd1 : '0;
            end
        end
    end

    // Decoded outputs are registered from the next-state counters so they line up
    // with hCount/vCount in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            hCount      <= '0;
            vCount      <= '0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_count <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
            hCount  <= h_next;
            vCount  <= v_next;
            hSync   <= sync_level(h_next, 10'(H_SYNC));
            vSync   <= sync_level(v_next, 10'(V_SYNC));
            bright  <= in_window(h_next, 10'(H_VIS_START), 10'(H_VIS_END)) &&
                       in_window(v_next, 10'(V_VIS_START), 10'(V_VIS_END));
            if (frame_tick) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
